adder_operand_stager: RTL and testbench
=======================================

ADDER_OPERAND_STAGER -- requirements
Module: adder_operand_stager

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 8, select-block width of the downstream adder; WIDTH SHALL be a multiple of it.
REQ-003 SHALL have parameter SUB_BLOCK_WIDTH, default 4, lookahead sub-block width of the downstream adder; passed through only.
REQ-004 SHALL have port iClk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port iRst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports iA, iB  input  WIDTH  upstream operands.
REQ-007 SHALL have port iC  input  1  upstream carry-in.
REQ-008 SHALL have port iValid  input  1  upstream operands valid.
REQ-009 SHALL have port oReady  output  1  stager can accept.
REQ-010 SHALL have ports oA, oB  output  WIDTH  staged operands to adder.
REQ-011 SHALL have port oC  output  1  staged carry-in to adder.
REQ-012 SHALL have port oValid  output  1  staged operands valid.
REQ-013 SHALL have port iReady  input  1  adder side accepts.
REQ-014 SHALL have port oCount  output  16  count of completed output transfers.

Function
REQ-015 Accept SHALL occur when iValid && oReady; transfer SHALL occur when oValid && iReady.
REQ-016 Occupancy SHALL be tracked by FSM EMPTY (0), ONE (1), FULL (2); FULL uses output register plus one skid register.
REQ-017 EMPTY: accept -> load output register, go ONE; no accept -> stay EMPTY.
REQ-018 ONE: accept and transfer -> load output register with new operands, stay ONE; accept only -> load skid register, go FULL; transfer only -> go EMPTY; neither -> stay ONE.
REQ-019 FULL: transfer -> move skid into output register, go ONE; no transfer -> stay FULL.
REQ-020 oReady SHALL be a registered output, 1 in EMPTY and ONE, 0 in FULL; no combinational path iReady->oReady.
REQ-021 oValid SHALL be 1 exactly in ONE and FULL; latency iValid accept to oValid SHALL be 1 cycle.
REQ-022 oA/oB/oC SHALL stay stable while oValid && !iReady; order SHALL be strictly FIFO, no drop, no duplicate.
REQ-023 oCount SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-024 iValid while oReady=0 SHALL be ignored; upstream holds its data.

Reset
REQ-025 While iRst=1: state EMPTY, oValid=0, oReady=0, oA=oB=0, oC=0, skid cleared, oCount=0.
REQ-026 oReady SHALL be 1 in the first cycle after iRst falls.
REQ-027 Reset mid-operation SHALL discard all held operands; no transfer completes in the reset cycle.

Configuration
REQ-028 Macro ADDER_OPERAND_STAGER_SUB_EN SHALL gate subtraction support.
REQ-029 With macro defined: extra port iSub input 1; when accepted with iSub=1, stored B SHALL be ~iB and stored carry 1; iSub=0 as REQ-030.
REQ-030 Without macro: iSub absent; operands and iC stored unmodified.

Structure
REQ-031 Shared package fast_arith_pkg SHALL hold FSM state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the count width constant (16).
REQ-032 One sub-module operand_register SHALL hold {A, B, C} with load enable and synchronous clear; instantiated twice (output, skid).

Verification
REQ-033 Reset: iRst=1 two cycles -> oValid=0, oReady=0, oCount=0; one cycle after release oReady=1.
REQ-034 Single op: iA=0x0000_00FF, iB=0x0000_0001, iC=0, iReady=1 -> next cycle oValid=1, oA=0xFF, oB=0x1, then EMPTY, oCount=1.
REQ-035 Backpressure: iReady=0, push 0x11, 0x22 -> FULL, oReady=0, oA=0x11 held; third push 0x33 ignored; iReady=1 -> outputs 0x11 then 0x22, 0x33 never seen.
REQ-036 Streaming: iValid=iReady=1 for 100 cycles with iA=n -> 100 in-order transfers, state stays ONE, oCount=100.
REQ-037 Wrap: 65537 transfers -> oCount=1.
REQ-038 With ADDER_OPERAND_STAGER_SUB_EN: iA=5, iB=3, iSub=1 -> oB=0xFFFF_FFFC, oC=1 (sum 2 downstream); reset asserted while FULL -> next cycle oValid=0.

Source files
------------

// File: rtl/fast_arith_pkg.sv
// Shared types for the fast-arithmetic operand path.
// Holds stager occupancy encodings and the transfer-count width.
package fast_arith_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stager_state_t;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/operand_register.sv
// One {A, B, C} operand slot for the adder stager.
// Clear wins over load.
module operand_register #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oA,
  output logic [WIDTH-1:0] oB,
  output logic             oC
);

  logic [2*WIDTH:0] r_data;

  always_ff @(posedge iClk) begin
    if (iClr) begin
      r_data <= '0;
    end else if (iLoad) begin
      r_data <= {iA, iB, iC};
    end
  end

  assign {oA, oB, oC} = r_data;

endmodule

// File: rtl/adder_operand_stager.sv
// Two-deep skid stage feeding operands to a carry-select adder.
// Optional subtraction: define ADDER_OPERAND_STAGER_SUB_EN.
module adder_operand_stager
  import fast_arith_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int BLOCK_WIDTH     = 8,
  parameter int SUB_BLOCK_WIDTH = 4
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  input  logic               iC,
`ifdef ADDER_OPERAND_STAGER_SUB_EN
  input  logic               iSub,
`endif
  input  logic               iValid,
  output logic               oReady,
  output logic [WIDTH-1:0]   oA,
  output logic [WIDTH-1:0]   oB,
  output logic               oC,
  output logic               oValid,
  input  logic               iReady,
  output logic [COUNT_W-1:0] oCount
);

  if ((WIDTH % BLOCK_WIDTH) != 0 ||
      (BLOCK_WIDTH % SUB_BLOCK_WIDTH) != 0) begin : g_bad_cfg
    $error("adder_operand_stager: block widths must divide WIDTH");
  end

  stager_state_t r_state;
  stager_state_t w_next;
  logic          r_ready;
  logic [COUNT_W-1:0] r_count;

  logic w_acc;
  logic w_xfer;
  logic w_load_out;
  logic w_load_skid;
  logic w_from_skid;

  logic [WIDTH-1:0] w_in_a;
  logic [WIDTH-1:0] w_in_b;
  logic             w_in_c;
  logic [WIDTH-1:0] w_skid_a;
  logic [WIDTH-1:0] w_skid_b;
  logic             w_skid_c;
  logic [WIDTH-1:0] w_out_a_d;
  logic [WIDTH-1:0] w_out_b_d;
  logic             w_out_c_d;

  // Subtract is a - b = a + ~b + 1, folded in before storage.
`ifdef ADDER_OPERAND_STAGER_SUB_EN
  assign w_in_a = iA;
  assign w_in_b = iSub ? ~iB : iB;
  assign w_in_c = iSub ? 1'b1 : iC;
`else
  assign w_in_a = iA;
  assign w_in_b = iB;
  assign w_in_c = iC;
`endif

  assign oValid = (r_state == ONE) || (r_state == FULL);
  assign oReady = r_ready;
  assign oCount = r_count;
  assign w_acc  = iValid && r_ready;
  assign w_xfer = oValid && iReady;

  always_comb begin
    w_next      = r_state;
    w_load_out  = 1'b0;
    w_load_skid = 1'b0;
    w_from_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_load_out = 1'b1;
          w_next     = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_xfer) begin
          w_load_out = 1'b1;
        end else if (w_acc) begin
          w_load_skid = 1'b1;
          w_next      = FULL;
        end else if (w_xfer) begin
          w_next = EMPTY;
        end
      end
      FULL: begin
        if (w_xfer) begin
          w_load_out  = 1'b1;
          w_from_skid = 1'b1;
          w_next      = ONE;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  assign w_out_a_d = w_from_skid ? w_skid_a : w_in_a;
  assign w_out_b_d = w_from_skid ? w_skid_b : w_in_b;
  assign w_out_c_d = w_from_skid ? w_skid_c : w_in_c;

  operand_register #(.WIDTH(WIDTH)) u_out (
    .iClk  (iClk),
    .iClr  (iRst),
    .iLoad (w_load_out),
    .iA    (w_out_a_d),
    .iB    (w_out_b_d),
    .iC    (w_out_c_d),
    .oA    (oA),
    .oB    (oB),
    .oC    (oC)
  );

  operand_register #(.WIDTH(WIDTH)) u_skid (
    .iClk  (iClk),
    .iClr  (iRst),
    .iLoad (w_load_skid),
    .iA    (w_in_a),
    .iB    (w_in_b),
    .iC    (w_in_c),
    .oA    (w_skid_a),
    .oB    (w_skid_b),
    .oC    (w_skid_c)
  );

  // oReady comes from a flop so iReady never reaches it combinationally.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != FULL);
      if (w_xfer) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_operand_stager.sv
// Directed bench for adder_operand_stager.
// Covers ADDER_OPERAND_STAGER_SUB_EN when defined.
module tb_adder_operand_stager;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iC;
`ifdef ADDER_OPERAND_STAGER_SUB_EN
  logic        iSub;
`endif
  logic        iValid;
  logic        oReady;
  logic [31:0] oA;
  logic [31:0] oB;
  logic        oC;
  logic        oValid;
  logic        iReady;
  logic [15:0] oCount;

  int n_vec = 0;
  int n_bad = 0;

  always #5 iClk = ~iClk;

  adder_operand_stager #(
    .WIDTH           (32),
    .BLOCK_WIDTH     (8),
    .SUB_BLOCK_WIDTH (4)
  ) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iA     (iA),
    .iB     (iB),
    .iC     (iC),
`ifdef ADDER_OPERAND_STAGER_SUB_EN
    .iSub   (iSub),
`endif
    .iValid (iValid),
    .oReady (oReady),
    .oA     (oA),
    .oB     (oB),
    .oC     (oC),
    .oValid (oValid),
    .iReady (iReady),
    .oCount (oCount)
  );

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    iRst   = 1'b1;
    iA     = '0;
    iB     = '0;
    iC     = 1'b0;
`ifdef ADDER_OPERAND_STAGER_SUB_EN
    iSub   = 1'b0;
`endif
    iValid = 1'b0;
    iReady = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_ready", 32'(oReady), 32'd0);
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_oa", oA, 32'd0);
    iRst = 1'b0;
    tick();
    chk("rel_ready", 32'(oReady), 32'd1);
    chk("rel_valid", 32'(oValid), 32'd0);

    // Single operation
    iA = 32'h0000_00FF;
    iB = 32'h0000_0001;
    iC = 1'b0;
    iValid = 1'b1;
    iReady = 1'b1;
    tick();
    chk("one_valid", 32'(oValid), 32'd1);
    chk("one_oa", oA, 32'h0000_00FF);
    chk("one_ob", oB, 32'h0000_0001);
    chk("one_oc", 32'(oC), 32'd0);
    iValid = 1'b0;
    tick();
    chk("one_empty", 32'(oValid), 32'd0);
    chk("one_count", 32'(oCount), 32'd1);

    // Backpressure: fill both slots, third push ignored
    iReady = 1'b0;
    iValid = 1'b1;
    iA = 32'h11; iB = 32'h11; iC = 1'b0;
    tick();
    chk("bp1_valid", 32'(oValid), 32'd1);
    chk("bp1_ready", 32'(oReady), 32'd1);
    iA = 32'h22; iB = 32'h22; iC = 1'b1;
    tick();
    chk("bp2_ready", 32'(oReady), 32'd0);
    chk("bp2_oa", oA, 32'h11);
    iA = 32'h33; iB = 32'h33; iC = 1'b0;
    tick();
    chk("bp3_ready", 32'(oReady), 32'd0);
    chk("bp3_oa", oA, 32'h11);
    chk("bp3_oc", 32'(oC), 32'd0);
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    chk("drain1_oa", oA, 32'h22);
    chk("drain1_oc", 32'(oC), 32'd1);
    chk("drain1_ready", 32'(oReady), 32'd1);
    chk("drain1_count", 32'(oCount), 32'd2);
    tick();
    chk("drain2_valid", 32'(oValid), 32'd0);
    chk("drain2_count", 32'(oCount), 32'd3);

    // Reset while FULL discards held operands
    iReady = 1'b0;
    iValid = 1'b1;
    iA = 32'h44;
    tick();
    iA = 32'h55;
    tick();
    chk("full_ready", 32'(oReady), 32'd0);
    iRst = 1'b1;
    iReady = 1'b1;
    tick();
    chk("midrst_valid", 32'(oValid), 32'd0);
    chk("midrst_count", 32'(oCount), 32'd0);
    chk("midrst_oa", oA, 32'd0);
    iRst = 1'b0;
    iValid = 1'b0;
    tick();
    chk("midrst_rel", 32'(oValid), 32'd0);

    // Streaming 100 in-order transfers
    iValid = 1'b1;
    iReady = 1'b1;
    iB = '0;
    iC = 1'b0;
    for (int n = 0; n < 100; n++) begin
      iA = 32'(n);
      tick();
      chk("stream_oa", oA, 32'(n));
      chk("stream_ready", 32'(oReady), 32'd1);
    end
    iValid = 1'b0;
    tick();
    chk("stream_valid", 32'(oValid), 32'd0);
    chk("stream_count", 32'(oCount), 32'd100);

    // Counter wrap over 65537 transfers
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    tick();
    iValid = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      iA = 32'(n);
      tick();
    end
    chk("wrap_ffff", 32'(oCount), 32'h0000_FFFF);
    tick();
    chk("wrap_zero", 32'(oCount), 32'd0);
    iValid = 1'b0;
    tick();
    chk("wrap_one", 32'(oCount), 32'd1);

`ifdef ADDER_OPERAND_STAGER_SUB_EN
    // Subtraction 5 - 3
    iA = 32'd5;
    iB = 32'd3;
    iC = 1'b0;
    iSub = 1'b1;
    iValid = 1'b1;
    iReady = 1'b0;
    tick();
    chk("sub_ob", oB, 32'hFFFF_FFFC);
    chk("sub_oc", 32'(oC), 32'd1);
    chk("sub_sum", oA + oB + 32'(oC), 32'd2);
    iSub = 1'b0;
    iB = 32'd7;
    tick();
    chk("sub_full", 32'(oReady), 32'd0);
    iRst = 1'b1;
    iValid = 1'b0;
    tick();
    chk("sub_rst_valid", 32'(oValid), 32'd0);
    iRst = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
